instr_fetch_buffer: RTL and testbench
=====================================

// Module: instr_fetch_buffer
// PURPOSE
//   Parametrised successor to the single-entry instruction register of the multicycle RISC-V core.
//   Sits between instruction memory and decode.
//   Holds a DEPTH-entry prefetch queue of {pc, word} pairs plus the architectural instruction register `inst`.
//   Decode consumes with IRWrite exactly as before.
//   Adds backpressure, a same-cycle bypass when the queue is empty, and a flush for taken branches/jumps.
// PARAMETERS
//   XLEN   32  instruction/data word width
//   PC_W   32  program-counter width carried with each word
//   DEPTH  4   queue entries; power of two, >= 2
// PORTS
//   clk        in   1               system clock, all state on rising edge
//   reset      in   1               asynchronous, active-high; clears all state
//   MemData    in   XLEN            fetched instruction word
//   mem_pc     in   PC_W            address of MemData
//   mem_valid  in   1               MemData/mem_pc valid this cycle
//   mem_ready  out  1               buffer accepts a word this cycle (combinational)
//   IRWrite    in   1               load next instruction into inst
//   flush      in   1               discard queue and incoming word
//   inst       out  XLEN            instruction register
//   inst_pc    out  PC_W            pc of inst
//   inst_valid out  1               inst holds an unconsumed, unflushed instruction
//   count      out  $clog2(DEPTH+1) occupied queue entries
//   empty      out  1               count == 0
//   full       out  1               count == DEPTH
// BEHAVIOUR
//   - Reset (async assert, released synchronously to clk):
//     - inst=0, inst_pc=0, inst_valid=0, count=0, empty=1, full=0, pointers=0.
//   - Accept:
//     - mem_ready = !flush && (!full || (IRWrite && !empty)).
//     - Push when mem_valid && mem_ready.
//   - IRWrite with queue non-empty:
//     - inst/inst_pc <= head entry on the next edge; inst_valid <= 1; head popped.
//   - IRWrite with queue empty and mem_valid:
//     - Bypass: inst <= MemData, inst_pc <= mem_pc, inst_valid <= 1 on the next edge.
//     - Word is NOT enqueued; count stays 0. Matches the legacy 1-cycle IR latency.
//   - IRWrite with queue empty and !mem_valid:
//     - inst/inst_pc hold; inst_valid <= 0 (decode must stall).
//   - No IRWrite: inst/inst_pc/inst_valid hold.
//   - Simultaneous push + pop when full:
//     - Legal; count unchanged; FIFO order preserved (old head -> inst, new word -> tail).
//   - Simultaneous push + pop otherwise: count unchanged.
//   - Pointer wrap: rd/wr pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty derive from count only.
//   - Flush has priority over everything:
//     - Next edge: count=0, pointers=0, inst_valid=0; IRWrite and mem_valid that cycle are ignored.
//     - inst/inst_pc hold their value (debug visibility).
//   - Reset mid-operation: all queued words lost immediately; outputs at reset values.
//   - Push attempted while !mem_ready: word dropped; memory side must hold mem_valid until mem_ready.
//   - count/empty/full are registered-state derived, never combinational from inputs.
// STRUCTURE
//   - Shared package riscv_pkg: XLEN default, NOP constant 32'h0000_0013, fetch_entry_t struct {pc, word}.
//   - One sub-module: ifb_fifo (storage array, rd/wr pointers, count, push/pop/clear).
//     Top level owns the inst register, bypass mux and flush priority.
// TESTING
//   1. Legacy mode, DEPTH=4:
//      - reset 1 cycle, then MemData=200000, mem_pc=0, mem_valid=1, IRWrite=1.
//      - Next edge: inst=200000, inst_valid=1, count=0.
//      - Assert reset: inst=0, inst_valid=0 immediately.
//   2. Fill, no IRWrite:
//      - push pc 0,4,8,12 with words 0xA0..0xA3.
//      - full=1, count=4, mem_ready=0.
//      - 5th word 0xA4 not accepted (count stays 4).
//   3. Full with IRWrite and mem_valid (0xA4 @pc16) same cycle:
//      - inst=0xA0/pc0, count=4.
//      - Four further IRWrites yield 0xA1,0xA2,0xA3,0xA4 in order (wrap exercised).
//   4. Flush with count=3 and IRWrite=1:
//      - next edge count=0, inst_valid=0, inst unchanged.
//      - IRWrite on the empty queue afterwards gives inst_valid=0.
//   5. Drain to empty: IRWrite with mem_valid=0 -> inst holds, inst_valid=0, empty=1.
//   6. Random push/pop 10k cycles vs. scoreboard queue model:
//      - inst sequence, pc and count match every cycle.
//      - Repeat with DEPTH=2 and DEPTH=8.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V fetch path: default widths,
// the canonical NOP encoding and the {pc, word} prefetch entry layout.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int PC_W_DEF = 32;

  localparam logic [XLEN_DEF-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] word;
  } fetch_entry_t;

  // Width of a packed {pc, word} queue entry for arbitrary widths.
  function automatic int entry_width(input int pc_w, input int xlen);
    return pc_w + xlen;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Prefetch queue storage for instr_fetch_buffer: DEPTH-entry circular buffer
// with wrapping rd/wr pointers, an occupancy counter and a synchronous clear.
module ifb_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // The owner never pushes into a full queue without popping, nor pops an
  // empty one; full/empty therefore come from the count alone.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: prefetch queue between instruction memory and
// decode, plus the architectural instruction register loaded by IRWrite.
module instr_fetch_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [XLEN-1:0]            MemData,
  input  logic [PC_W-1:0]            mem_pc,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic                       IRWrite,
  input  logic                       flush,
  output logic [XLEN-1:0]            inst,
  output logic [PC_W-1:0]            inst_pc,
  output logic                       inst_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int EW = entry_width(PC_W, XLEN);

  logic [XLEN-1:0] inst_q, inst_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;

  logic [EW-1:0]   head;
  logic            q_empty, q_full;
  logic            pop, push, bypass;

  // Handshake: a word transfers on a cycle where mem_valid && mem_ready are
  // both high; a word offered while mem_ready is low is not taken, so the
  // memory side keeps it asserted. Flush blocks acceptance outright, and a
  // full queue still accepts when decode pops the head in the same cycle.
  assign mem_ready = !flush && (!q_full || (IRWrite && !q_empty));
  assign pop       = !flush && IRWrite && !q_empty;
  assign bypass    = !flush && IRWrite && q_empty && mem_valid;
  assign push      = mem_valid && mem_ready && !bypass;

  ifb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .clear_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({mem_pc, MemData}),
    .rdata_o (head),
    .count_o (count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  // Flush drops the valid flag but leaves inst/inst_pc visible for debug.
  always_comb begin
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    if (flush) begin
      inst_valid_d = 1'b0;
    end else if (IRWrite) begin
      if (!q_empty) begin
        inst_d       = head[XLEN-1:0];
        inst_pc_d    = head[EW-1:XLEN];
        inst_valid_d = 1'b1;
      end else if (mem_valid) begin
        inst_d       = MemData;
        inst_pc_d    = mem_pc;
        inst_valid_d = 1'b1;
      end else begin
        inst_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign empty      = q_empty;
  assign full       = q_full;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: three instances (DEPTH 2/4/8) share one
// stimulus stream and are checked against a queue-based reference model.
module tb_instr_fetch_buffer;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MemData;
  logic [31:0] mem_pc;
  logic        mem_valid;
  logic        IRWrite;
  logic        flush;

  logic [31:0] inst_w  [NI];
  logic [31:0] pc_w    [NI];
  logic        iv_w    [NI];
  logic        rdy_w   [NI];
  logic        emp_w   [NI];
  logic        full_w  [NI];
  logic [3:0]  cnt_w   [NI];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = 2 << g;
    logic [$clog2(D+1)-1:0] c;
    instr_fetch_buffer #(.XLEN(32), .PC_W(32), .DEPTH(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemData    (MemData),
      .mem_pc     (mem_pc),
      .mem_valid  (mem_valid),
      .mem_ready  (rdy_w[g]),
      .IRWrite    (IRWrite),
      .flush      (flush),
      .inst       (inst_w[g]),
      .inst_pc    (pc_w[g]),
      .inst_valid (iv_w[g]),
      .count      (c),
      .empty      (emp_w[g]),
      .full       (full_w[g])
    );
    assign cnt_w[g] = 4'(c);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered list of {pc, word} per instance plus the
  // instruction register contents.
  logic [63:0] mq    [NI][$];
  logic [31:0] m_inst[NI];
  logic [31:0] m_pc  [NI];
  logic        m_v   [NI];
  logic [63:0] m_e;
  int          m_n, m_d;
  logic        m_rdy, m_byp;

  initial begin
    for (int g = 0; g < NI; g++) begin
      m_inst[g] = '0; m_pc[g] = '0; m_v[g] = 1'b0;
    end
  end

  always begin
    @(posedge clk);
    for (int g = 0; g < NI; g++) begin
      m_d = 2 << g;
      m_n = mq[g].size();
      if (reset) begin
        mq[g].delete(); m_inst[g] = '0; m_pc[g] = '0; m_v[g] = 1'b0;
      end else if (flush) begin
        mq[g].delete(); m_v[g] = 1'b0;
      end else begin
        m_rdy = (m_n != m_d) || (IRWrite && m_n != 0);
        m_byp = 1'b0;
        if (IRWrite) begin
          if (m_n != 0) begin
            m_e = mq[g].pop_front();
            m_pc[g] = m_e[63:32]; m_inst[g] = m_e[31:0]; m_v[g] = 1'b1;
          end else if (mem_valid) begin
            m_pc[g] = mem_pc; m_inst[g] = MemData; m_v[g] = 1'b1; m_byp = 1'b1;
          end else begin
            m_v[g] = 1'b0;
          end
        end
        if (mem_valid && m_rdy && !m_byp) mq[g].push_back({mem_pc, MemData});
      end
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      m_d = 2 << g;
      if (reset) begin
        mq[g].delete(); m_inst[g] = '0; m_pc[g] = '0; m_v[g] = 1'b0;
      end
      m_n = mq[g].size();
      chk($sformatf("d%0d.inst", m_d),       64'(inst_w[g]), 64'(m_inst[g]));
      chk($sformatf("d%0d.inst_pc", m_d),    64'(pc_w[g]),   64'(m_pc[g]));
      chk($sformatf("d%0d.inst_valid", m_d), 64'(iv_w[g]),   64'(m_v[g]));
      chk($sformatf("d%0d.count", m_d),      64'(cnt_w[g]),  64'(m_n));
      chk($sformatf("d%0d.empty", m_d),      64'(emp_w[g]),  64'(m_n == 0));
      chk($sformatf("d%0d.full", m_d),       64'(full_w[g]), 64'(m_n == m_d));
      chk($sformatf("d%0d.mem_ready", m_d),  64'(rdy_w[g]),
          64'(!flush && ((m_n != m_d) || (IRWrite && m_n != 0))));
    end
  end

  int mv_p [4] = '{80, 40, 60, 70};
  int ir_p [4] = '{30, 70, 50, 90};

  initial begin
    reset = 1'b1; MemData = '0; mem_pc = '0; mem_valid = 1'b0; IRWrite = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b0;
    chk("t1.reset.inst",  64'(inst_w[1]), 64'h0);
    chk("t1.reset.valid", 64'(iv_w[1]),   64'h0);
    chk("t1.reset.count", 64'(cnt_w[1]),  64'h0);
    chk("t1.reset.empty", 64'(emp_w[1]),  64'h1);
    chk("t1.reset.full",  64'(full_w[1]), 64'h0);

    // Legacy single-cycle IR load through the bypass.
    MemData = 32'h0020_0000; mem_pc = 32'h0; mem_valid = 1'b1; IRWrite = 1'b1;
    #1 chk("t1.ready", 64'(rdy_w[1]), 64'h1);
    tick();
    chk("t1.inst",  64'(inst_w[1]), 64'h0020_0000);
    chk("t1.valid", 64'(iv_w[1]),   64'h1);
    chk("t1.count", 64'(cnt_w[1]),  64'h0);
    mem_valid = 1'b0; IRWrite = 1'b0; reset = 1'b1;
    #1;
    chk("t1.async.inst",  64'(inst_w[1]), 64'h0);
    chk("t1.async.valid", 64'(iv_w[1]),   64'h0);
    tick();
    reset = 1'b0;

    // Fill without IRWrite.
    for (int i = 0; i < 4; i++) begin
      MemData = 32'hA0 + 32'(i); mem_pc = 32'(4 * i); mem_valid = 1'b1;
      tick();
    end
    chk("t2.count", 64'(cnt_w[1]),  64'h4);
    chk("t2.full",  64'(full_w[1]), 64'h1);
    MemData = 32'hA4; mem_pc = 32'd16;
    #1 chk("t2.ready", 64'(rdy_w[1]), 64'h0);
    tick();
    chk("t2.dropped.count", 64'(cnt_w[1]), 64'h4);

    // Full with simultaneous pop and push.
    IRWrite = 1'b1;
    #1 chk("t3.ready", 64'(rdy_w[1]), 64'h1);
    tick();
    chk("t3.inst",  64'(inst_w[1]), 64'hA0);
    chk("t3.pc",    64'(pc_w[1]),   64'h0);
    chk("t3.count", 64'(cnt_w[1]),  64'h4);
    mem_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t3.drain%0d.inst", i),  64'(inst_w[1]), 64'(32'hA0 + 32'(i)));
      chk($sformatf("t3.drain%0d.pc", i),    64'(pc_w[1]),   64'(4 * i));
      chk($sformatf("t3.drain%0d.count", i), 64'(cnt_w[1]),  64'(4 - i));
    end

    // Flush with three queued entries and IRWrite asserted.
    IRWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      MemData = 32'hB0 + 32'(i); mem_pc = 32'(20 + 4 * i); mem_valid = 1'b1;
      tick();
    end
    chk("t4.count3", 64'(cnt_w[1]), 64'h3);
    flush = 1'b1; IRWrite = 1'b1; MemData = 32'hB3; mem_pc = 32'd32;
    #1 chk("t4.ready", 64'(rdy_w[1]), 64'h0);
    tick();
    chk("t4.count", 64'(cnt_w[1]),  64'h0);
    chk("t4.valid", 64'(iv_w[1]),   64'h0);
    chk("t4.inst",  64'(inst_w[1]), 64'hA4);
    chk("t4.pc",    64'(pc_w[1]),   64'h10);
    flush = 1'b0; mem_valid = 1'b0;
    tick();
    chk("t4.after.valid", 64'(iv_w[1]),   64'h0);
    chk("t4.after.inst",  64'(inst_w[1]), 64'hA4);

    // Drain to empty, then IRWrite with nothing available.
    IRWrite = 1'b0; MemData = 32'hC0; mem_pc = 32'd36; mem_valid = 1'b1;
    tick();
    chk("t5.count", 64'(cnt_w[1]), 64'h1);
    mem_valid = 1'b0; IRWrite = 1'b1;
    tick();
    chk("t5.pop.inst",  64'(inst_w[1]), 64'hC0);
    chk("t5.pop.valid", 64'(iv_w[1]),   64'h1);
    chk("t5.pop.empty", 64'(emp_w[1]),  64'h1);
    tick();
    chk("t5.stall.inst",  64'(inst_w[1]), 64'hC0);
    chk("t5.stall.valid", 64'(iv_w[1]),   64'h0);
    chk("t5.stall.empty", 64'(emp_w[1]),  64'h1);

    // Randomised traffic in phases with different fill/drain bias.
    IRWrite = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 2500; c++) begin
        mem_valid = ($urandom_range(0, 99) < mv_p[p]);
        IRWrite   = ($urandom_range(0, 99) < ir_p[p]);
        flush     = ($urandom_range(0, 99) < 2);
        reset     = ($urandom_range(0, 999) == 0);
        MemData   = $urandom;
        mem_pc    = mem_pc + 32'd4;
        tick();
      end
    end

    reset = 1'b0; flush = 1'b0; mem_valid = 1'b0; IRWrite = 1'b0;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
